frequency_meter: RTL and testbench

Measures the frequency of an incoming square wave, the reverse of the button-driven frequency/period setter. The setter turns a kHz value into a half-period count at 100 MHz. This block counts clock cycles between rising edges of a signal, such as the switching waveform returned from the power stage. It produces the frequency in kHz, in the same 8-bit format fed to the dec2seg/seven_segment display path, and the half-period count in the same 32-bit format as the setter's period word. This lets the commanded and actual values be compared directly.

---
 rtl/frequency_meter.sv | 135 +++++++++++++
 tb/tb_frequency_meter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_meter.sv
// frequency_meter: measures the period of i_signal in clock cycles and reports
// the frequency in kHz (saturated to 8 bits) and half-period, with timeout.
module frequency_meter #(
   parameter int unsigned CLK_FREQ_KHZ = 100000,
   parameter int unsigned TIMEOUT      = 65535
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_signal,
   output logic [7:0]  o_frequency,
   output logic [31:0] o_half_period,
   output logic        o_valid,
   output logic        o_timeout
);

   localparam logic [31:0] DIVIDEND  = 32'(CLK_FREQ_KHZ);
   localparam logic [31:0] CNT_LIMIT = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

   state_t      state;
   logic        s1, s2, s3;
   logic        rise;
   logic        timeout_hit;
   logic [31:0] cnt;
   logic        armed;
   logic        discard;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [32:0] trial;
   logic [4:0]  iter;
   logic [7:0]  freq_sat;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= i_signal;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_comb begin
      rise        = s2 & ~s3;
      timeout_hit = (cnt == CNT_LIMIT) && !rise;
      // Restoring step: shift next dividend bit into the partial remainder.
      trial       = {remainder, quotient[31]} - {1'b0, divisor};
      freq_sat    = (|quotient[31:8]) ? 8'hFF : quotient[7:0];
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= '0;
      end else if (cnt != CNT_LIMIT) begin
         cnt <= cnt + 32'd1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state         <= IDLE;
         armed         <= 1'b0;
         discard       <= 1'b0;
         divisor       <= '0;
         quotient      <= '0;
         remainder     <= '0;
         iter          <= '0;
         o_frequency   <= '0;
         o_half_period <= '0;
         o_valid       <= 1'b0;
         o_timeout     <= 1'b1;
      end else begin
         o_valid <= 1'b0;

         if (rise) begin
            armed <= 1'b1;
         end else if (timeout_hit) begin
            armed <= 1'b0;
         end

         // A timeout during a divide lets it run out but suppresses its result.
         if (timeout_hit) begin
            o_frequency   <= '0;
            o_half_period <= '0;
            o_timeout     <= 1'b1;
            if (state != IDLE) begin
               discard <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (rise && armed) begin
                  divisor   <= cnt + 32'd1;
                  quotient  <= DIVIDEND;
                  remainder <= '0;
                  iter      <= '0;
                  discard   <= 1'b0;
                  state     <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (!trial[32]) begin
                  remainder <= trial[31:0];
                  quotient  <= {quotient[30:0], 1'b1};
               end else begin
                  remainder <= {remainder[30:0], quotient[31]};
                  quotient  <= {quotient[30:0], 1'b0};
               end
               iter <= iter + 5'd1;
               if (iter == 5'd31) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (!discard && !timeout_hit) begin
                  o_frequency   <= freq_sat;
                  o_half_period <= {1'b0, divisor[31:1]};
                  o_timeout     <= 1'b0;
                  o_valid       <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: table-driven, directed and randomized checks of
// frequency_meter against a rise-time based reference model.
module tb_frequency_meter;

   localparam int T       = 5000;
   localparam int CLK_KHZ = 100000;
   localparam int LAT     = 35;   // edge0 of a rise to the o_valid edge

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sig;
   logic [7:0]  freq;
   logic [31:0] half;
   logic        valid;
   logic        tmo;

   frequency_meter #(.CLK_FREQ_KHZ(CLK_KHZ), .TIMEOUT(T)) dut (
      .i_clock      (clk),
      .i_reset      (rst_n),
      .i_signal     (sig),
      .o_frequency  (freq),
      .o_half_period(half),
      .o_valid      (valid),
      .o_timeout    (tmo)
   );

   always #5 clk = ~clk;

   typedef struct {
      int period;
      int high;
      int exp_freq;
      int exp_half;
   } vec_t;

   typedef struct {
      int at_edge;
      int freq;
      int half;
   } exp_t;

   vec_t vecs[8];
   exp_t exp_q[$];

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int valid_count = 0;
   int last_rise = 0;
   int m_last;
   int m_acc;
   bit m_armed;

   always @(posedge clk) cyc = cyc + 1;

   function automatic void chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void model_reset();
      m_armed = 1'b0;
      m_last  = -1000000;
      m_acc   = -1000000;
      exp_q.delete();
   endfunction

   // r = index of the clock edge at which the first synchronizer sees the high.
   function automatic void model_rise(input int r);
      exp_t e;
      int   p;
      if (r - m_last > T) m_armed = 1'b0;
      if (!m_armed) begin
         m_armed = 1'b1;
      end else if (r - m_acc >= LAT - 1) begin
         p         = r - m_last;
         e.at_edge = r + LAT;
         e.freq    = (CLK_KHZ / p > 255) ? 255 : CLK_KHZ / p;
         e.half    = p / 2;
         exp_q.push_back(e);
         m_acc = r;
      end
      m_last = r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (valid) begin
         valid_count++;
         if (exp_q.size() == 0) begin
            chk("spurious_valid", longint'(valid), 0);
         end else begin
            e = exp_q.pop_front();
            chk("valid_cycle", longint'(cyc), longint'(e.at_edge));
            chk("meas_freq", longint'(freq), longint'(e.freq));
            chk("meas_half", longint'(half), longint'(e.half));
         end
      end else if (exp_q.size() != 0 && exp_q[0].at_edge < cyc) begin
         chk("missing_valid", longint'(valid), 1);
         void'(exp_q.pop_front());
      end
   end

   task automatic wave(input int period, input int high, input int n);
      for (int k = 0; k < n; k++) begin
         sig       = 1'b1;
         last_rise = cyc + 1;
         model_rise(cyc + 1);
         repeat (high) @(negedge clk);
         sig = 1'b0;
         repeat (period - high) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sig   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int vc0;
      int target;
      int r2;
      int p;
      int h;

      vecs[0] = '{2000, 1000,  50, 1000};
      vecs[1] = '{1428,  714,  70,  714};
      vecs[2] = '{1000,  500, 100,  500};
      vecs[3] = '{ 300,  150, 255,  150};
      vecs[4] = '{ 392,  196, 255,  196};
      vecs[5] = '{ 393,  100, 254,  196};
      vecs[6] = '{2500, 1250,  40, 1250};
      vecs[7] = '{  40,   20, 255,   20};

      rst_n = 1'b0;
      sig   = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset held while the input toggles, then released with no input.
      for (int i = 0; i < 20; i++) begin
         sig = ~sig;
         @(negedge clk);
      end
      sig = 1'b0;
      chk("rst_freq",    longint'(freq),  0);
      chk("rst_half",    longint'(half),  0);
      chk("rst_valid",   longint'(valid), 0);
      chk("rst_timeout", longint'(tmo),   1);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("idle_freq",    longint'(freq),  0);
      chk("idle_half",    longint'(half),  0);
      chk("idle_valid",   longint'(valid), 0);
      chk("idle_timeout", longint'(tmo),   1);

      foreach (vecs[i]) begin
         do_reset();
         wave(vecs[i].period, vecs[i].high, 2);
         repeat (40) @(negedge clk);
         chk("tbl_freq",    longint'(freq), longint'(vecs[i].exp_freq));
         chk("tbl_half",    longint'(half), longint'(vecs[i].exp_half));
         chk("tbl_timeout", longint'(tmo),  0);
      end

      // Fast burst: the rise arriving mid-divide is dropped.
      do_reset();
      vc0 = valid_count;
      wave(20, 10, 8);
      repeat (40) @(negedge clk);
      chk("burst_valids", longint'(valid_count - vc0), 4);
      chk("burst_freq",   longint'(freq), 255);
      chk("burst_half",   longint'(half), 10);

      do_reset();
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 3) == 0) p = int'($urandom_range(30, 40));
         else p = int'($urandom_range(41, 1200));
         h = int'($urandom_range(1, p - 1));
         wave(p, h, 1);
      end
      repeat (40) @(negedge clk);
      chk("rand_drained", longint'(exp_q.size()), 0);

      // Timeout after a 50 kHz lock, then relock.
      do_reset();
      wave(2000, 1000, 2);
      repeat (40) @(negedge clk);
      chk("lock_freq",    longint'(freq), 50);
      chk("lock_timeout", longint'(tmo),  0);
      target = last_rise + T + 2;
      while (cyc < target - 1) @(negedge clk);
      chk("pre_to_timeout", longint'(tmo),  0);
      chk("pre_to_freq",    longint'(freq), 50);
      @(negedge clk);
      chk("to_timeout", longint'(tmo),  1);
      chk("to_freq",    longint'(freq), 0);
      chk("to_half",    longint'(half), 0);
      vc0 = valid_count;
      wave(2000, 1000, 2);
      repeat (40) @(negedge clk);
      chk("relock_valids",  longint'(valid_count - vc0), 1);
      chk("relock_freq",    longint'(freq), 50);
      chk("relock_timeout", longint'(tmo),  0);

      // Reset ten cycles into a divide.
      sig = 1'b1;
      r2  = cyc + 1;
      model_rise(r2);
      while (cyc < r2 + 12) @(negedge clk);
      chk("pre_abort_freq", longint'(freq), 50);
      rst_n = 1'b0;
      sig   = 1'b0;
      model_reset();
      #1;
      chk("abort_freq",    longint'(freq),  0);
      chk("abort_half",    longint'(half),  0);
      chk("abort_valid",   longint'(valid), 0);
      chk("abort_timeout", longint'(tmo),   1);
      vc0 = valid_count;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("abort_no_valid", longint'(valid_count - vc0), 0);
      wave(2000, 1000, 1);
      chk("arm_only_no_valid", longint'(valid_count - vc0), 0);
      wave(2000, 1000, 1);
      repeat (40) @(negedge clk);
      chk("post_abort_valids", longint'(valid_count - vc0), 1);
      chk("post_abort_freq",   longint'(freq), 50);
      chk("post_abort_half",   longint'(half), 1000);

      chk("queue_empty", longint'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
